// File: rtl/alpha_trim_mean_if.sv
// Window/result bus between the sort stage and the alpha-trimmed mean stage.
// The sorter side drives window + rank order; the mean stage returns the pixel.
interface alpha_trim_mean_if #(
  parameter int unsigned DN     = 25,
  parameter int unsigned DW     = 8,
  parameter int unsigned DW_SEQ = $clog2(DN)
) ();

  logic                 start;
  logic [DW*DN-1:0]     data_in;
  logic [DW_SEQ*DN-1:0] seq_in;
  logic [DW-1:0]        mean_out;
  logic                 mean_valid;
  logic                 busy;

  modport master (
    output start, data_in, seq_in,
    input  mean_out, mean_valid, busy
  );

  modport slave (
    input  start, data_in, seq_in,
    output mean_out, mean_valid, busy
  );

endinterface

// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean: sums the middle NK ranks of a latched window one per cycle,
// then divides by NK (round-half-up) with a bit-serial restoring divider.
module alpha_trim_mean #(
  parameter int unsigned DN     = 25,
  parameter int unsigned DW     = 8,
  parameter int unsigned DW_SEQ = $clog2(DN),
  parameter int unsigned TRIM   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  alpha_trim_mean_if.slave bus
);

  localparam int unsigned NK     = DN - 2 * TRIM;
  localparam int unsigned SUM_W  = DW + $clog2(NK) + 1;
  localparam int unsigned CW     = $clog2(SUM_W);
  localparam int unsigned LAST_K = DN - TRIM - 1;

  if (2 * TRIM >= DN) begin : g_trim_chk
    $error("alpha_trim_mean: 2*TRIM must be smaller than DN");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       data_q [DN];
  logic [DW_SEQ-1:0]   seq_q  [DN];
  logic [DW_SEQ-1:0]   k_q;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [SUM_W-1:0]    dq_q, dq_d;
  logic [SUM_W-1:0]    rem_q, rem_d;
  logic [CW-1:0]       cnt_q;
  logic [DW-1:0]       mean_out_q;
  logic                mean_valid_q;
  logic                busy_q;

  logic                load_c, acc_en_c, acc_last_c, div_en_c, div_last_c, done_c;
  logic [DW_SEQ-1:0]   idx_c;
  logic [DW-1:0]       sel_c;
  logic [SUM_W:0]      shift_c;
  logic                fits_c;

  assign acc_last_c = (k_q == DW_SEQ'(LAST_K));
  assign div_last_c = (cnt_q == CW'(SUM_W - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_ACC;
      S_ACC:  if (acc_last_c) state_d = S_DIV;
      S_DIV:  if (div_last_c) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    load_c   = 1'b0;
    acc_en_c = 1'b0;
    div_en_c = 1'b0;
    done_c   = 1'b0;
    unique case (state_q)
      S_IDLE: load_c   = bus.start;
      S_ACC:  acc_en_c = 1'b1;
      S_DIV:  div_en_c = 1'b1;
      S_DONE: done_c   = 1'b1;
      default: ;
    endcase
  end

  // Rank-k sample select; an out-of-range index matches no sample and yields 0
  always_comb begin
    idx_c = seq_q[k_q];
    sel_c = '0;
    for (int unsigned i = 0; i < DN; i++) begin
      if (idx_c == DW_SEQ'(i)) sel_c = data_q[i];
    end
  end

  // One restoring-divide step: dividend shifts out MSB-first, quotient shifts in
  always_comb begin
    acc_d   = acc_q + SUM_W'(sel_c);
    shift_c = {rem_q, dq_q[SUM_W-1]};
    fits_c  = (shift_c >= (SUM_W+1)'(NK));
    rem_d   = fits_c ? SUM_W'(shift_c - (SUM_W+1)'(NK)) : SUM_W'(shift_c);
    dq_d    = {dq_q[SUM_W-2:0], fits_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DN; i++) begin
        data_q[i] <= '0;
        seq_q[i]  <= '0;
      end
      k_q          <= '0;
      acc_q        <= '0;
      dq_q         <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      mean_out_q   <= '0;
      mean_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (load_c) begin
        for (int unsigned i = 0; i < DN; i++) begin
          data_q[i] <= bus.data_in[i*DW +: DW];
          seq_q[i]  <= bus.seq_in[i*DW_SEQ +: DW_SEQ];
        end
        k_q   <= DW_SEQ'(TRIM);
        acc_q <= '0;
      end
      if (acc_en_c) begin
        acc_q <= acc_d;
        k_q   <= k_q + DW_SEQ'(1);
        if (acc_last_c) begin
          dq_q  <= acc_d + SUM_W'(NK / 2);
          rem_q <= '0;
          cnt_q <= '0;
        end
      end
      if (div_en_c) begin
        dq_q  <= dq_d;
        rem_q <= rem_d;
        cnt_q <= cnt_q + CW'(1);
      end
      if (done_c) mean_out_q <= dq_q[DW-1:0];
      mean_valid_q <= done_c;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign bus.mean_out   = mean_out_q;
  assign bus.mean_valid = mean_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Self-checking bench for alpha_trim_mean: directed windows, randomized windows
// against a sort-based reference, handshake and reset-abort scenarios.
module tb_alpha_trim_mean;

  localparam int DN     = 25;
  localparam int DW     = 8;
  localparam int DW_SEQ = $clog2(DN);
  localparam int TRIM   = 6;
  localparam int NK     = DN - 2 * TRIM;
  localparam int LAT    = 27;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alpha_trim_mean_if #(.DN(DN), .DW(DW), .DW_SEQ(DW_SEQ)) bus_if ();

  alpha_trim_mean #(.DN(DN), .DW(DW), .DW_SEQ(DW_SEQ), .TRIM(TRIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int win  [DN];
  int sq   [DN];
  int vals [DN];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference by rank order: mean of the samples named by the kept ranks
  function automatic int model_by_rank();
    int sum = 0;
    for (int k = TRIM; k < DN - TRIM; k++)
      if (sq[k] >= 0 && sq[k] < DN) sum += win[sq[k]];
    return (sum + NK / 2) / NK;
  endfunction

  // Reference by value: sort the window and average the middle NK values
  function automatic int model_by_sort();
    int q[$];
    int sum = 0;
    for (int i = 0; i < DN; i++) q.push_back(win[i]);
    q.sort();
    for (int k = TRIM; k < DN - TRIM; k++) sum += q[k];
    return (sum + NK / 2) / NK;
  endfunction

  task automatic set_identity();
    for (int k = 0; k < DN; k++) sq[k] = k;
  endtask

  task automatic argsort_seq();
    int t;
    set_identity();
    for (int i = 1; i < DN; i++)
      for (int j = i; j > 0 && win[sq[j-1]] > win[sq[j]]; j--) begin
        t = sq[j]; sq[j] = sq[j-1]; sq[j-1] = t;
      end
  endtask

  task automatic random_perm();
    int j, t;
    set_identity();
    for (int i = DN - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = sq[i]; sq[i] = sq[j]; sq[j] = t;
    end
  endtask

  // Scatter vals[] over random window positions and give the matching rank order
  task automatic place_shuffled();
    random_perm();
    for (int i = 0; i < DN; i++) win[sq[i]] = vals[i];
    argsort_seq();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < DN; i++) begin
      bus_if.data_in[i*DW +: DW]         = DW'(win[i]);
      bus_if.seq_in[i*DW_SEQ +: DW_SEQ]  = DW_SEQ'(sq[i]);
    end
    bus_if.start = 1'b1;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < DN; i++) begin
      bus_if.data_in[i*DW +: DW]        = DW'($urandom);
      bus_if.seq_in[i*DW_SEQ +: DW_SEQ] = DW_SEQ'($urandom);
    end
  endtask

  task automatic release_start();
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    scramble_inputs();
  endtask

  task automatic launch();
    @(negedge clk);
    drive_inputs();
    release_start();
  endtask

  // Returns at the negedge of the mean_valid cycle (or after the cycle budget)
  task automatic wait_result(input string tag, input int exp);
    int  n      = 0;
    int  busy_n = 0;
    bit  seen   = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (bus_if.mean_valid) seen = 1'b1;
      else if (bus_if.busy)  busy_n++;
    end
    check_eq({tag, ".valid_seen"}, int'(seen), 1);
    if (seen) begin
      check_eq({tag, ".latency"}, n - 1, LAT);
      check_eq({tag, ".mean"}, int'(bus_if.mean_out), exp);
      check_eq({tag, ".busy_cycles"}, busy_n, LAT);
      check_eq({tag, ".busy_at_valid"}, int'(bus_if.busy), 0);
    end
  endtask

  task automatic run_window(input string tag, input int exp);
    launch();
    wait_result(tag, exp);
    @(negedge clk);
    check_eq({tag, ".pulse_one"}, int'(bus_if.mean_valid), 0);
    check_eq({tag, ".hold"}, int'(bus_if.mean_out), exp);
  endtask

  initial begin
    int exp_a, exp_b, n, pulses;
    bit seen;

    rst_n          = 1'b0;
    bus_if.start   = 1'b0;
    bus_if.data_in = '0;
    bus_if.seq_in  = '0;
    repeat (3) @(negedge clk);
    check_eq("reset.mean_out", int'(bus_if.mean_out), 0);
    check_eq("reset.mean_valid", int'(bus_if.mean_valid), 0);
    check_eq("reset.busy", int'(bus_if.busy), 0);
    rst_n = 1'b1;

    for (int i = 0; i < DN; i++) win[i] = 100;
    set_identity();
    run_window("flat100", 100);

    for (int i = 0; i < DN; i++) win[i] = 10 * i;
    set_identity();
    run_window("ramp", 120);

    for (int i = 0; i < DN; i++) vals[i] = (i < 6) ? 0 : (i < 18) ? 10 : (i == 18) ? 17 : 255;
    place_shuffled();
    run_window("round_half_up", 11);

    for (int i = 0; i < DN; i++) vals[i] = (i < 6) ? 0 : (i < 19) ? 50 : 255;
    place_shuffled();
    run_window("impulse", 50);

    for (int i = 0; i < DN; i++) win[i] = 255;
    random_perm();
    run_window("all255", 255);

    // Out-of-range rank indices: a kept rank contributes 0, a trimmed one nothing
    for (int i = 0; i < DN; i++) win[i] = $urandom_range(255, 0);
    set_identity();
    sq[TRIM + 3] = 31;
    sq[DN - 1]   = 27;
    run_window("bad_index", model_by_rank());

    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < DN; i++)
        win[i] = (it % 3 == 0) ? 60 * $urandom_range(4, 0) : $urandom_range(255, 0);
      if (it % 2 == 0) begin
        argsort_seq();
        run_window("rand_sorted", model_by_sort());
      end else begin
        random_perm();
        run_window("rand_perm", model_by_rank());
      end
    end

    // Starts during ACC and DIV are ignored; a start in the valid cycle is taken
    for (int i = 0; i < DN; i++) win[i] = $urandom_range(255, 0);
    argsort_seq();
    exp_a = model_by_sort();
    launch();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (bus_if.mean_valid) seen = 1'b1;
      else if (n == 5 || n == 18) begin
        scramble_inputs();
        bus_if.start = 1'b1;
      end else bus_if.start = 1'b0;
    end
    bus_if.start = 1'b0;
    check_eq("hs_first.valid_seen", int'(seen), 1);
    check_eq("hs_first.latency", n - 1, LAT);
    check_eq("hs_first.mean", int'(bus_if.mean_out), exp_a);
    for (int i = 0; i < DN; i++) win[i] = $urandom_range(255, 0);
    argsort_seq();
    exp_b = model_by_sort();
    drive_inputs();
    release_start();
    wait_result("hs_back2back", exp_b);
    @(negedge clk);
    check_eq("hs_back2back.pulse_one", int'(bus_if.mean_valid), 0);

    // Reset mid-accumulation aborts the window
    for (int i = 0; i < DN; i++) win[i] = $urandom_range(255, 1);
    random_perm();
    launch();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid.mean_out", int'(bus_if.mean_out), 0);
    check_eq("rst_mid.mean_valid", int'(bus_if.mean_valid), 0);
    check_eq("rst_mid.busy", int'(bus_if.busy), 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.mean_valid) pulses++;
    end
    check_eq("rst_mid.no_valid", pulses, 0);
    check_eq("rst_mid.busy_after", int'(bus_if.busy), 0);

    for (int i = 0; i < DN; i++) win[i] = $urandom_range(255, 0);
    random_perm();
    run_window("after_reset", model_by_rank());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
